// File: rtl/hbridge_deadtime_driver.sv
// H-bridge gate driver: turns forward/reverse PWM commands into four gate drives
// with dead time, minimum on-pulse, pair exclusion and a latched fault shutdown.
module hbridge_deadtime_driver #(
  parameter int DT_WIDTH    = 8,
  parameter int MP_WIDTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                motor_positive,
  input  logic                motor_negative,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic [MP_WIDTH-1:0] min_pulse,
  input  logic                fault_in,
  input  logic                fault_clear,
  output logic                hs_a,
  output logic                ls_a,
  output logic                hs_b,
  output logic                ls_b,
  output logic                fault_latched,
  output logic                illegal_cmd,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    REV   = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MP_WIDTH-1:0] MP_ONE = {{(MP_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state;
  state_t                   state_next;
  state_t                   cmd;
  logic [SYNC_STAGES-1:0]   fault_sync;
  logic                     fault_s;
  logic [MP_WIDTH-1:0]      on_cnt;
  logic [DT_WIDTH-1:0]      dt_cnt;
  logic [MP_WIDTH:0]        on_plus;
  logic                     on_reached;
  logic                     load_dt;

  // A programmed dead time of zero still yields one all-off cycle.
  function automatic logic [DT_WIDTH-1:0] dead_load(input logic [DT_WIDTH-1:0] d);
    return (d == '0) ? DT_ONE : d;
  endfunction

  function automatic logic [MP_WIDTH-1:0] sat_inc(input logic [MP_WIDTH-1:0] v);
    return (v == '1) ? v : v + MP_ONE;
  endfunction

  // Fault input synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_sync <= '0;
    end else begin
      fault_sync <= {fault_sync[SYNC_STAGES-2:0], fault_in};
    end
  end

  assign fault_s = fault_sync[SYNC_STAGES-1];

  always_comb begin
    cmd = IDLE;
    unique case ({motor_positive, motor_negative})
      2'b10:   cmd = FWD;
      2'b01:   cmd = REV;
      default: cmd = IDLE;
    endcase
  end

  // on_cnt lags the cycles spent on by one, so compare one step ahead without wrap.
  assign on_plus    = {1'b0, on_cnt} + {1'b0, MP_ONE};
  assign on_reached = on_plus >= {1'b0, min_pulse};

  always_comb begin
    state_next = state;
    load_dt    = 1'b0;
    if (fault_s) begin
      state_next = FAULT;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd != IDLE) state_next = cmd;
        end
        FWD, REV: begin
          if (cmd != state && on_reached) begin
            state_next = DEAD;
            load_dt    = 1'b1;
          end
        end
        DEAD: begin
          // Exit follows the command seen on the expiry edge itself.
          if (dt_cnt <= DT_ONE) state_next = cmd;
        end
        FAULT: begin
          if (fault_clear && cmd == IDLE) begin
            state_next = DEAD;
            load_dt    = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      on_cnt        <= '0;
      dt_cnt        <= '0;
      hs_a          <= 1'b0;
      ls_a          <= 1'b0;
      hs_b          <= 1'b0;
      ls_b          <= 1'b0;
      fault_latched <= 1'b0;
      illegal_cmd   <= 1'b0;
    end else begin
      state <= state_next;

      if ((state == FWD || state == REV) && state_next == state) begin
        on_cnt <= sat_inc(on_cnt);
      end else begin
        on_cnt <= '0;
      end

      if (load_dt) begin
        dt_cnt <= dead_load(dead_time);
      end else if (state == DEAD && dt_cnt > DT_ONE) begin
        dt_cnt <= dt_cnt - DT_ONE;
      end

      hs_a          <= (state_next == FWD);
      ls_b          <= (state_next == FWD);
      hs_b          <= (state_next == REV);
      ls_a          <= (state_next == REV);
      fault_latched <= (state_next == FAULT);
      illegal_cmd   <= motor_positive & motor_negative;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Bench for hbridge_deadtime_driver: directed scenarios with literal expectations,
// then randomized commands/faults checked every cycle against a gate-phase model.
module tb_hbridge_deadtime_driver;

  localparam int DT_W = 8;
  localparam int MP_W = 8;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            motor_positive = 1'b0;
  logic            motor_negative = 1'b0;
  logic [DT_W-1:0] dead_time = 8'd5;
  logic [MP_W-1:0] min_pulse = 8'd0;
  logic            fault_in = 1'b0;
  logic            fault_clear = 1'b0;
  logic            hs_a, ls_a, hs_b, ls_b;
  logic            fault_latched, illegal_cmd;
  logic [2:0]      state_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  hbridge_deadtime_driver #(
    .DT_WIDTH(DT_W), .MP_WIDTH(MP_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset),
    .motor_positive(motor_positive), .motor_negative(motor_negative),
    .dead_time(dead_time), .min_pulse(min_pulse),
    .fault_in(fault_in), .fault_clear(fault_clear),
    .hs_a(hs_a), .ls_a(ls_a), .hs_b(hs_b), .ls_b(ls_b),
    .fault_latched(fault_latched), .illegal_cmd(illegal_cmd),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which gate set is on (0 none,1 fwd,2 rev,3 dead,4 fault), how long it
  // has been on, how many off cycles remain, and the delayed view of fault_in.
  int   m_phase = 0;
  int   m_on = 0;
  int   m_off = 0;
  bit   fq[$];
  logic exp_ill = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_on = 0; m_off = 0; exp_ill = 1'b0;
      fq.delete();
      for (int i = 0; i < SYNC; i++) fq.push_back(1'b0);
    end else begin
      bit fs;
      int c;
      fs = fq[SYNC-1];
      fq.push_front(fault_in);
      void'(fq.pop_back());
      c = (motor_positive && !motor_negative) ? 1 :
          (!motor_positive && motor_negative) ? 2 : 0;
      if (fs) begin
        m_phase = 4;
      end else if (m_phase == 0) begin
        if (c != 0) begin m_phase = c; m_on = 1; end
      end else if (m_phase == 1 || m_phase == 2) begin
        if (c != m_phase && m_on >= int'(min_pulse)) begin
          m_phase = 3;
          m_off = (dead_time == 0) ? 1 : int'(dead_time);
        end else begin
          m_on++;
        end
      end else if (m_phase == 3) begin
        if (m_off <= 1) begin m_phase = c; m_on = 1; end
        else m_off--;
      end else begin
        if (fault_clear && c == 0) begin
          m_phase = 3;
          m_off = (dead_time == 0) ? 1 : int'(dead_time);
        end
      end
      exp_ill = motor_positive & motor_negative;
    end
  end

  // Per-cycle comparison, sampled half a period after the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [8:0] exp_vec;
      exp_vec = {m_phase == 1, m_phase == 2, m_phase == 2, m_phase == 1,
                 m_phase == 4, exp_ill, 3'(m_phase)};
      check("cycle_outputs", {hs_a, ls_a, hs_b, ls_b, fault_latched, illegal_cmd, state_out},
            exp_vec);
      check("pair_exclusion", {hs_a & ls_a, hs_b & ls_b}, 2'b00);
    end
  end

  task automatic set_cmd(input logic p, input logic n);
    motor_positive = p;
    motor_negative = n;
  endtask

  // Counts consecutive post-edge samples with state_out == s, starting at the current one.
  task automatic count_run(input logic [2:0] s, output int n);
    n = 0;
    while (state_out == s && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_gates", {hs_a, ls_a, hs_b, ls_b}, 4'b0000);
    check("reset_state", state_out, 3'd0);
    reset = 1'b0;
    chk_en = 1;

    // dead_time=5, min_pulse=0: FWD 20 clk then REV
    @(negedge clk); set_cmd(1, 0);
    @(posedge clk); #1;
    check("fwd_latency", {hs_a, ls_a, hs_b, ls_b}, 4'b1001);
    repeat (20) @(negedge clk);
    set_cmd(0, 1);
    @(posedge clk); #1;
    count_run(3'd1, n); check("fwd_drop_latency", n, 0);
    count_run(3'd3, n); check("dead5_len", n, 5);
    check("rev_gates", {hs_a, ls_a, hs_b, ls_b}, 4'b0110);

    // dead_time=0 behaves as one off cycle
    @(negedge clk); dead_time = 8'd0; set_cmd(1, 0);
    @(posedge clk); #1;
    count_run(3'd2, n); check("rev_drop_latency", n, 0);
    count_run(3'd3, n); check("dead0_len", n, 1);
    check("dead0_to_fwd", state_out, 3'd1);
    @(negedge clk); set_cmd(0, 0);
    @(posedge clk); #1;
    count_run(3'd3, n); check("dead0_to_idle_len", n, 1);
    check("idle_after_off", state_out, 3'd0);
    @(negedge clk); set_cmd(1, 0);
    @(posedge clk); #1;
    check("idle_to_fwd_1clk", {hs_a, ls_a, hs_b, ls_b}, 4'b1001);

    // min_pulse=10: 3 clk command still gives 10 on-cycles
    @(negedge clk); dead_time = 8'd2; set_cmd(0, 0);
    @(posedge clk); #1;
    count_run(3'd3, n); check("dead2_len", n, 2);
    @(negedge clk); min_pulse = 8'd10; set_cmd(1, 0);
    repeat (3) @(negedge clk);
    set_cmd(0, 0);
    @(posedge clk); #1;
    count_run(3'd1, n); check("min_pulse_extra_on", n, 7);
    count_run(3'd3, n); check("min_pulse_dead", n, 2);
    check("min_pulse_idle", state_out, 3'd0);

    // Both commands high
    @(negedge clk); min_pulse = 8'd0; set_cmd(1, 1);
    @(posedge clk); #1;
    check("illegal_idle_pulse", {illegal_cmd, hs_a, ls_a, hs_b, ls_b, state_out}, 8'b1_0000_000);
    @(negedge clk); set_cmd(0, 0);
    @(posedge clk); #1;
    check("illegal_clears", illegal_cmd, 1'b0);
    @(negedge clk); set_cmd(1, 0);
    repeat (2) @(negedge clk);
    set_cmd(1, 1);
    @(posedge clk); #1;
    count_run(3'd1, n); check("illegal_fwd_drop", n, 0);
    count_run(3'd3, n); check("illegal_fwd_dead", n, 2);
    check("illegal_fwd_idle", state_out, 3'd0);

    // Fault during REV
    @(negedge clk); set_cmd(0, 1);
    repeat (3) @(negedge clk);
    fault_in = 1'b1;
    @(negedge clk); fault_in = 1'b0;
    @(posedge clk); #1;
    check("fault_sync_delay", state_out, 3'd2);
    @(posedge clk); #1;
    check("fault_shutdown", {hs_a, ls_a, hs_b, ls_b, fault_latched, state_out}, 8'b0000_1_100);
    @(negedge clk); set_cmd(1, 0); fault_clear = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("fault_hold_cmd_fwd", {fault_latched, state_out}, 4'b1_100);
    @(negedge clk); set_cmd(0, 0);
    @(posedge clk); #1;
    check("fault_exit_dead", {fault_latched, state_out}, 4'b0_011);
    count_run(3'd3, n); check("fault_exit_dead_len", n, 2);
    check("fault_exit_idle", {fault_latched, state_out}, 4'b0_000);
    @(negedge clk); fault_clear = 1'b0;

    // Asynchronous reset mid-FWD
    @(negedge clk); set_cmd(1, 0);
    repeat (2) @(negedge clk);
    check("pre_reset_fwd", {hs_a, ls_a, hs_b, ls_b}, 4'b1001);
    #2 reset = 1'b1; set_cmd(0, 0);
    #1;
    check("async_reset_gates", {hs_a, ls_a, hs_b, ls_b, state_out}, 7'b0000_000);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_state", state_out, 3'd0);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 12) begin
        logic [1:0] r;
        r = 2'($urandom_range(0, 3));
        set_cmd(r[1], r[0]);
      end
      if ($urandom_range(0, 39) == 0) dead_time = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) min_pulse = 8'($urandom_range(0, 12));
      fault_in    = ($urandom_range(0, 249) == 0);
      fault_clear = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
